cam_match_encoder: RTL and testbench
====================================

CAM_MATCH_ENCODER -- requirements
Module: cam_match_encoder

Interface
REQ-001 The block SHALL have no parameters: 32 CAM entries, 5-bit index, fixed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 match_valid_i  input  1  match vector offered.
REQ-006 match_vec_i  input  32  per-entry match bits; bit n = entry n hit.
REQ-007 match_ready_o  output  1  block can accept a vector.
REQ-008 flush_i  input  1  abandon remaining indices of current vector.
REQ-009 index_valid_o  output  1  index_o holds a valid matching entry.
REQ-010 index_o  output  5  matching entry number.
REQ-011 index_last_o  output  1  current index is the final hit of the vector.
REQ-012 index_ready_i  input  1  consumer accepts index_o.
REQ-013 miss_o  output  1  one-cycle pulse: captured vector had no hits.

Function
REQ-014 The block SHALL implement two states: IDLE and EMIT.
REQ-015 match_ready_o SHALL be 1 in IDLE and 0 in EMIT.
REQ-016 Capture SHALL occur on a rising edge with match_valid_i=1 and match_ready_o=1; match_vec_i is loaded into a 32-bit pending register.
REQ-017 A nonzero capture SHALL move IDLE->EMIT; index_valid_o SHALL rise the cycle after capture (latency 1).
REQ-018 A zero capture SHALL leave the block in IDLE and assert miss_o for exactly the next cycle.
REQ-019 In EMIT, index_o SHALL equal the lowest set bit position of pending; index_valid_o=1.
REQ-020 index_last_o SHALL be 1 in EMIT iff exactly one pending bit is set; 0 otherwise and in IDLE.
REQ-021 On index_valid_o=1 and index_ready_i=1, the emitted bit SHALL be cleared from pending.
REQ-022 If that bit was the last one, state SHALL return to IDLE; match_ready_o rises the next cycle.
REQ-023 index_o, index_valid_o and index_last_o SHALL hold stable while index_ready_i=0.
REQ-024 match_valid_i in EMIT SHALL be ignored; the vector is not captured.
REQ-025 flush_i=1 in EMIT SHALL clear pending and return to IDLE next cycle, overriding a simultaneous handshake (no further index emitted).
REQ-026 flush_i in IDLE SHALL have no effect; a simultaneous capture proceeds.
REQ-027 index_o SHALL be 0 whenever index_valid_o=0.

Reset
REQ-028 When rst_i=1 at a rising edge: state=IDLE, pending=0, miss_o=0. index_valid_o, index_last_o and index_o are 0, and match_ready_o is 1, from the following cycle.
REQ-029 Reset mid-EMIT SHALL discard all remaining indices; no index is emitted after reset.
REQ-030 rst_i SHALL take priority over flush_i, capture and handshake.

Configuration
REQ-031 Macro CAM_MATCH_COUNT_EN, when defined, SHALL add output match_count_o (6 bits): popcount of the captured vector, registered at capture, held until the next capture, 0 after reset.
REQ-032 Without CAM_MATCH_COUNT_EN the port and popcount logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Capture 0x0000_0000 -> miss_o=1 for one cycle; index_valid_o stays 0; match_ready_o stays 1.
REQ-034 Capture 0x8000_0011, index_ready_i=1 -> indices 0, 4, 31 on consecutive cycles; index_last_o only with 31; match_ready_o=1 the following cycle.
REQ-035 Capture 0x0000_0006, index_ready_i=0 for 3 cycles -> index_o=1 held stable; then ready=1 -> 1, 2 emitted.
REQ-036 Capture 0xFFFF_FFFF, flush_i=1 with index_ready_i=1 after index 2 is presented -> index 2 not consumed; IDLE next cycle; a new vector of 0x1 yields index 0 with last=1.
REQ-037 Capture 0x0000_0300, assert rst_i while index 8 is presented -> all outputs reset; index 9 is never emitted.
REQ-038 With CAM_MATCH_COUNT_EN: capture 0xF000_000F -> match_count_o=8 the cycle after capture.

Source files
------------

// File: rtl/cam_match_encoder.sv
// Serialises a 32-entry CAM match vector into a stream of hit indices, lowest entry first.
// Optional CAM_MATCH_COUNT_EN adds match_count_o, the popcount of the last captured vector.
module cam_match_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        match_valid_i,
  input  logic [31:0] match_vec_i,
  output logic        match_ready_o,
  input  logic        flush_i,
  output logic        index_valid_o,
  output logic [4:0]  index_o,
  output logic        index_last_o,
  input  logic        index_ready_i,
`ifdef CAM_MATCH_COUNT_EN
  output logic [5:0]  match_count_o,
`endif
  output logic        miss_o
);

  localparam int unsigned Entries = 32;
  localparam int unsigned IdxW    = 5;
  localparam int unsigned CntW    = 6;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [Entries-1:0]   pending_q, pending_d;
  logic [IdxW-1:0]      index_q, index_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 ready_q, ready_d;
  logic                 miss_q, miss_d;
  logic [IdxW-1:0]      low_idx;
  logic                 one_hot;
  logic                 capture;

  assign capture = (state_q == IDLE) && match_valid_i;

  // Next pending set and state; flush beats the index handshake in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    miss_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (match_valid_i) begin
          pending_d = match_vec_i;
          if (match_vec_i != '0) state_d = EMIT;
          else                   miss_d  = 1'b1;
        end
      end
      EMIT: begin
        if (flush_i) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (index_ready_i) begin
          pending_d = pending_q & ~(Entries'(1) << index_q);
          if (pending_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lowest set bit and single-hit detection of the next pending set.
  always_comb begin
    low_idx = '0;
    for (int i = Entries - 1; i >= 0; i--) begin
      if (pending_d[i]) low_idx = IdxW'(i);
    end
    one_hot = (pending_d != '0) && ((pending_d & (pending_d - Entries'(1))) == '0);
  end

  // Output values registered alongside the state so ports are flop-driven.
  always_comb begin
    valid_d = (state_d == EMIT);
    ready_d = (state_d == IDLE);
    index_d = valid_d ? low_idx : '0;
    last_d  = valid_d && one_hot;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ready_q   <= 1'b1;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      miss_q    <= miss_d;
    end
  end

  assign match_ready_o = ready_q;
  assign index_valid_o = valid_q;
  assign index_o       = index_q;
  assign index_last_o  = last_q;
  assign miss_o        = miss_q;

`ifdef CAM_MATCH_COUNT_EN
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < Entries; i++) begin
      count_d = count_d + CntW'(match_vec_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        count_q <= '0;
    else if (capture) count_q <= count_d;
  end

  assign match_count_o = count_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_cam_match_encoder.sv
// Directed bench for cam_match_encoder; outputs are sampled 1ns after each rising edge.
// Obs vector layout: {match_ready, index_valid, index_last, miss, index[4:0]}.
module tb_cam_match_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        match_valid_i;
  logic [31:0] match_vec_i;
  logic        match_ready_o;
  logic        flush_i;
  logic        index_valid_o;
  logic [4:0]  index_o;
  logic        index_last_o;
  logic        index_ready_i;
  logic        miss_o;
`ifdef CAM_MATCH_COUNT_EN
  logic [5:0]  match_count_o;
`endif

  int checks   = 0;
  int failures = 0;

  cam_match_encoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .match_valid_i (match_valid_i),
    .match_vec_i   (match_vec_i),
    .match_ready_o (match_ready_o),
    .flush_i       (flush_i),
    .index_valid_o (index_valid_o),
    .index_o       (index_o),
    .index_last_o  (index_last_o),
    .index_ready_i (index_ready_i),
`ifdef CAM_MATCH_COUNT_EN
    .match_count_o (match_count_o),
`endif
    .miss_o        (miss_o)
  );

  always #5 clk_i = ~clk_i;

  logic [8:0] obs;
  assign obs = {match_ready_o, index_valid_o, index_last_o, miss_o, index_o};

  // Expected-vector builder: ready, valid, last, miss, index.
  function automatic logic [8:0] ex(input logic r, input logic v, input logic l,
                                    input logic m, input logic [4:0] i);
    return {r, v, l, m, i};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; match_valid_i = 1'b0; match_vec_i = '0;
    flush_i = 1'b0; index_ready_i = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
`ifdef CAM_MATCH_COUNT_EN
    checks++;
    if (match_count_o !== 6'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", match_count_o);
    end
`endif
    rst_i = 1'b0;
  endtask

  task automatic test_miss();
    match_valid_i = 1'b1; match_vec_i = 32'h0000_0000;
    tick();
    match_valid_i = 1'b0;
    checks++;
    if (obs !== ex(1, 0, 0, 1, 0)) begin
      failures++; $display("FAIL miss_pulse got=%b exp=%b", obs, ex(1, 0, 0, 1, 0));
    end
    tick();
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL miss_end got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_multi_hit();
    logic [4:0] exp_idx [3];
    exp_idx[0] = 5'd0; exp_idx[1] = 5'd4; exp_idx[2] = 5'd31;
    index_ready_i = 1'b1;
    match_valid_i = 1'b1; match_vec_i = 32'h8000_0011;
    tick();
    match_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== ex(0, 1, (k == 2), 0, exp_idx[k])) begin
        failures++;
        $display("FAIL multi_idx%0d got=%b exp=%b", k, obs, ex(0, 1, (k == 2), 0, exp_idx[k]));
      end
      tick();
    end
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL multi_done got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
    index_ready_i = 1'b0;
  endtask

  task automatic test_stall_and_ignore();
    match_valid_i = 1'b1; match_vec_i = 32'h0000_0006;
    tick();
    // A second vector offered during EMIT must not be captured.
    match_vec_i = 32'hFFFF_0000;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== ex(0, 1, 0, 0, 5'd1)) begin
        failures++; $display("FAIL stall_hold%0d got=%b exp=%b", k, obs, ex(0, 1, 0, 0, 5'd1));
      end
      tick();
    end
    match_valid_i = 1'b0;
    checks++;
    if (obs !== ex(0, 1, 0, 0, 5'd1)) begin
      failures++; $display("FAIL stall_hold3 got=%b exp=%b", obs, ex(0, 1, 0, 0, 5'd1));
    end
    index_ready_i = 1'b1;
    tick();
    checks++;
    if (obs !== ex(0, 1, 1, 0, 5'd2)) begin
      failures++; $display("FAIL stall_idx2 got=%b exp=%b", obs, ex(0, 1, 1, 0, 5'd2));
    end
    tick();
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL stall_done got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
    index_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    index_ready_i = 1'b1;
    match_valid_i = 1'b1; match_vec_i = 32'hFFFF_FFFF;
    tick();
    match_valid_i = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== ex(0, 1, 0, 0, 5'd2)) begin
      failures++; $display("FAIL flush_pre got=%b exp=%b", obs, ex(0, 1, 0, 0, 5'd2));
    end
    flush_i = 1'b1;
    tick();
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL flush_idle got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
    // Flush held high in IDLE must not block the next capture.
    match_valid_i = 1'b1; match_vec_i = 32'h0000_0001;
    tick();
    match_valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (obs !== ex(0, 1, 1, 0, 5'd0)) begin
      failures++; $display("FAIL flush_new got=%b exp=%b", obs, ex(0, 1, 1, 0, 5'd0));
    end
    tick();
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL flush_new_done got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
    index_ready_i = 1'b0;
  endtask

  task automatic test_top_entry();
    index_ready_i = 1'b0;
    match_valid_i = 1'b1; match_vec_i = 32'h8000_0000;
    tick();
    match_valid_i = 1'b0;
    checks++;
    if (obs !== ex(0, 1, 1, 0, 5'd31)) begin
      failures++; $display("FAIL top_entry got=%b exp=%b", obs, ex(0, 1, 1, 0, 5'd31));
    end
    index_ready_i = 1'b1;
    tick();
    index_ready_i = 1'b0;
    checks++;
    if (obs !== ex(1, 0, 0, 0, 0)) begin
      failures++; $display("FAIL top_done got=%b exp=%b", obs, ex(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_emit();
    index_ready_i = 1'b0;
    match_valid_i = 1'b1; match_vec_i = 32'h0000_0300;
    tick();
    match_valid_i = 1'b0;
    checks++;
    if (obs !== ex(0, 1, 0, 0, 5'd8)) begin
      failures++; $display("FAIL rstmid_pre got=%b exp=%b", obs, ex(0, 1, 0, 0, 5'd8));
    end
    rst_i = 1'b1; index_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    rst_i = 1'b0; flush_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== ex(1, 0, 0, 0, 0)) begin
        failures++; $display("FAIL rstmid_post%0d got=%b exp=%b", k, obs, ex(1, 0, 0, 0, 0));
      end
      tick();
    end
    index_ready_i = 1'b0;
  endtask

`ifdef CAM_MATCH_COUNT_EN
  task automatic test_count();
    index_ready_i = 1'b1;
    match_valid_i = 1'b1; match_vec_i = 32'hF000_000F;
    tick();
    match_valid_i = 1'b0;
    checks++;
    if (match_count_o !== 6'd8) begin
      failures++; $display("FAIL count_capture got=%0d exp=8", match_count_o);
    end
    repeat (9) tick();
    checks++;
    if (match_count_o !== 6'd8) begin
      failures++; $display("FAIL count_hold got=%0d exp=8", match_count_o);
    end
    index_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_multi_hit();
    test_stall_and_ignore();
    test_flush();
    test_top_entry();
    test_reset_mid_emit();
`ifdef CAM_MATCH_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
